// File: rtl/game_pkg.sv
// Shared game-control definitions: state encodings and default tuning constants.
// Combinational definitions only; no latency.
// No flow control; constants consumed by the game sequencer.
`ifndef SCORELEN
`define SCORELEN 12
`endif

package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } game_state_t;

    localparam int SCORE_W_DEF    = `SCORELEN;
    localparam int LEVEL_STEP_DEF = 100;
    localparam int LEVEL_W_DEF    = 3;
    localparam int MAX_LEVEL_DEF  = 7;
    localparam int HOLD_CYC_DEF   = 200;

endpackage

// File: rtl/game_flow_ctrl_btn_sync_edge.sv
// Three-flop synchronizer for a raw asynchronous button with rising-edge detect.
// Rise is valid two edges after the button is first sampled high; one pulse per press.
// No backpressure; a held button produces a single rise.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic s1, s2, s3;

    // Synchronizer chain; s3 keeps the previous synchronized level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-state sequencer: buttons/collision -> score-counter controls, high score, speed level.
// State and all outputs update on the clk3 edge after a synchronized button rise or collide.
// No backpressure; button presses arriving while a state ignores them are dropped.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W    = `SCORELEN,
    parameter int LEVEL_STEP = LEVEL_STEP_DEF,
    parameter int LEVEL_W    = LEVEL_W_DEF,
    parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic               clk3,
    input  logic               reset,
    input  logic               btn_jump,
    input  logic               btn_pause,
    input  logic               collide,
    input  logic [SCORE_W-1:0] score,
    output logic               start,
    output logic               pause,
    output logic               score_rst_n,
    output logic               game_over,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] high_score,
    output logic [LEVEL_W-1:0] level
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic              jump_rise, pause_rise;
    game_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              new_game;
    logic              start_d, pause_d, game_over_d;
    logic [SCORE_W-1:0] prev_score;
    logic              level_hit;

    btn_sync_edge u_jump_sync (
        .clk   (clk3),
        .rst_n (reset),
        .btn   (btn_jump),
        .rise  (jump_rise)
    );

    btn_sync_edge u_pause_sync (
        .clk   (clk3),
        .rst_n (reset),
        .btn   (btn_pause),
        .rise  (pause_rise)
    );

    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYC - 1));
    assign new_game  = (state_d == ST_RUN) && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign level_hit = (score != prev_score) && (score != '0)
                     && ((score % SCORE_W'(LEVEL_STEP)) == '0);
    assign state     = state_q;

    // State register.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: collision has priority over pause while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (jump_rise)              state_d = ST_RUN;
            ST_RUN:    if (collide)                state_d = ST_OVER;
                       else if (pause_rise)        state_d = ST_PAUSED;
            ST_PAUSED: if (pause_rise)             state_d = ST_RUN;
            ST_OVER:   if (jump_rise && hold_done) state_d = ST_RUN;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        start_d     = (state_d == ST_RUN) || (state_d == ST_PAUSED);
        pause_d     = (state_d == ST_PAUSED);
        game_over_d = (state_d == ST_OVER);
    end

    // Registered control outputs; the score clear pulses low on new-game entry only.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            start       <= 1'b0;
            pause       <= 1'b0;
            game_over   <= 1'b0;
            score_rst_n <= 1'b1;
        end else begin
            start       <= start_d;
            pause       <= pause_d;
            game_over   <= game_over_d;
            score_rst_n <= ~new_game;
        end
    end

    // Hold-off counter: restarts on OVER entry, saturates at HOLD_CYC-1.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if ((state_q != ST_OVER) && (state_d == ST_OVER)) begin
            hold_cnt <= '0;
        end else if ((state_q == ST_OVER) && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // High score captured at the end of a running game.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            high_score <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_OVER) && (score > high_score)) begin
            high_score <= score;
        end
    end

    // Speed level: bump on each fresh multiple of LEVEL_STEP while running; cleared per new game.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            level      <= '0;
            prev_score <= '0;
        end else if (new_game) begin
            level      <= '0;
            prev_score <= '0;
        end else if (state_q == ST_RUN) begin
            prev_score <= score;
            if (level_hit && (level != LEVEL_W'(MAX_LEVEL)))
                level <= level + LEVEL_W'(1);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int SW   = SCORE_W_DEF;
    localparam int HOLD = HOLD_CYC_DEF;

    logic          clk3 = 1'b0;
    logic          reset;
    logic          btn_jump, btn_pause, collide;
    logic [SW-1:0] score;
    logic          start, pause, score_rst_n, game_over;
    logic [1:0]    state;
    logic [SW-1:0] high_score;
    logic [2:0]    level;

    int errors = 0;
    int checks = 0;

    game_flow_ctrl dut (
        .clk3        (clk3),
        .reset       (reset),
        .btn_jump    (btn_jump),
        .btn_pause   (btn_pause),
        .collide     (collide),
        .score       (score),
        .start       (start),
        .pause       (pause),
        .score_rst_n (score_rst_n),
        .game_over   (game_over),
        .state       (state),
        .high_score  (high_score),
        .level       (level)
    );

    always #5 clk3 = ~clk3;

    // Called at a negedge: one-cycle button pulse, returns at the negedge after the edge
    // where the resulting state change (if any) lands.
    task automatic pulse(input int which);
        if (which == 0) btn_jump = 1'b1; else btn_pause = 1'b1;
        @(negedge clk3);
        btn_jump = 1'b0; btn_pause = 1'b0;
        @(negedge clk3);
        @(negedge clk3);
    endtask

    // From the negedge just after OVER entry: wait out the hold-off, then jump.
    task automatic restart();
        repeat (HOLD) @(negedge clk3);
        pulse(0);
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_jump = 1'b0; btn_pause = 1'b0; collide = 1'b0; score = '0;
        repeat (2) @(negedge clk3);
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (start !== 1'b0)      begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (pause !== 1'b0)      begin errors++; $display("FAIL reset_pause got=%b exp=0", pause); end
        checks++; if (score_rst_n !== 1'b1) begin errors++; $display("FAIL reset_clr got=%b exp=1", score_rst_n); end
        checks++; if (game_over !== 1'b0)  begin errors++; $display("FAIL reset_over got=%b exp=0", game_over); end
        checks++; if (high_score !== '0)   begin errors++; $display("FAIL reset_hs got=%0d exp=0", high_score); end
        checks++; if (level !== 3'd0)      begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        reset = 1'b1;
        repeat (2) @(negedge clk3);
    endtask

    task automatic test_start();
        btn_jump = 1'b1;                       // sampled at edge n, held
        @(negedge clk3);                       // after n
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_n got=%0d exp=0", state); end
        @(negedge clk3);                       // after n+1
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_n1 got=%0d exp=0", state); end
        @(negedge clk3);                       // after n+2
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_n2_state got=%0d exp=1", state); end
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_n2_start got=%b exp=1", start); end
        checks++; if (score_rst_n !== 1'b0) begin errors++; $display("FAIL start_n2_clr got=%b exp=0", score_rst_n); end
        @(negedge clk3);                       // after n+3
        checks++; if (score_rst_n !== 1'b1) begin errors++; $display("FAIL start_n3_clr got=%b exp=1", score_rst_n); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_n3_state got=%0d exp=1", state); end
        repeat (3) @(negedge clk3);
        btn_jump = 1'b0;
        @(negedge clk3);
    endtask

    task automatic test_pause();
        btn_pause = 1'b1;                      // held several cycles: one rise only
        repeat (3) @(negedge clk3);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state got=%0d exp=2", state); end
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_out got=%b exp=1", pause); end
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL pause_start got=%b exp=1", start); end
        repeat (3) @(negedge clk3);
        btn_pause = 1'b0;
        @(negedge clk3);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_held got=%0d exp=2", state); end
        collide = 1'b1;
        pulse(0);
        collide = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_ignore got=%0d exp=2", state); end
        pulse(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state got=%0d exp=1", state); end
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL resume_pause got=%b exp=0", pause); end
        checks++; if (score_rst_n !== 1'b1) begin errors++; $display("FAIL resume_noclr got=%b exp=1", score_rst_n); end
    endtask

    task automatic test_high_score();
        score = 12'd120; collide = 1'b1;
        @(negedge clk3); collide = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL hs1_state got=%0d exp=3", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL hs1_over got=%b exp=1", game_over); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL hs1_start got=%b exp=0", start); end
        checks++; if (high_score !== 12'd120) begin errors++; $display("FAIL hs1_val got=%0d exp=120", high_score); end
        restart();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL hs_restart got=%0d exp=1", state); end
        score = 12'd250; collide = 1'b1;
        @(negedge clk3); collide = 1'b0;
        checks++; if (high_score !== 12'd250) begin errors++; $display("FAIL hs2_val got=%0d exp=250", high_score); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL hs2_over got=%b exp=1", game_over); end
        restart();
        score = 12'd90; collide = 1'b1;
        @(negedge clk3); collide = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL hs3_state got=%0d exp=3", state); end
        checks++; if (high_score !== 12'd250) begin errors++; $display("FAIL hs3_keep got=%0d exp=250", high_score); end
    endtask

    // Starts at the negedge right after OVER entry (edge E, hold counter 0).
    task automatic test_hold();
        repeat (7) @(negedge clk3);
        pulse(0);                              // rise judged at E+10
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL hold_early got=%0d exp=3", state); end
        repeat (186) @(negedge clk3);
        pulse(0);                              // rise judged at E+199, counter 198
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL hold_edge got=%0d exp=3", state); end
        pulse(0);                              // rise judged at E+202, saturated
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL hold_rel_state got=%0d exp=1", state); end
        checks++; if (score_rst_n !== 1'b0) begin errors++; $display("FAIL hold_rel_clr got=%b exp=0", score_rst_n); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL hold_rel_over got=%b exp=0", game_over); end
    endtask

    task automatic test_level();
        score = '0;
        @(negedge clk3);
        for (int v = 1; v <= 8; v++) begin
            score = SW'(v * 100 - 1);
            @(negedge clk3);
            score = SW'(v * 100);
            @(negedge clk3);
            checks++;
            if (level !== 3'((v > 7) ? 7 : v)) begin
                errors++; $display("FAIL level_%0d got=%0d exp=%0d", v * 100, level, (v > 7) ? 7 : v);
            end
            @(negedge clk3);
            checks++;
            if (level !== 3'((v > 7) ? 7 : v)) begin
                errors++; $display("FAIL level_hold_%0d got=%0d exp=%0d", v * 100, level, (v > 7) ? 7 : v);
            end
        end
    endtask

    task automatic test_collide_pause();
        score = 12'd55;
        @(negedge clk3);
        btn_pause = 1'b1;
        @(negedge clk3); btn_pause = 1'b0;
        @(negedge clk3); collide = 1'b1;       // pause rise and collide on the same edge
        @(negedge clk3); collide = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL cp_state got=%0d exp=3", state); end
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL cp_pause got=%b exp=0", pause); end
        checks++; if (level !== 3'd7) begin errors++; $display("FAIL cp_level_held got=%0d exp=7", level); end
        checks++; if (high_score !== 12'd250) begin errors++; $display("FAIL cp_hs got=%0d exp=250", high_score); end
        restart();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL newgame_level got=%0d exp=0", level); end
        pulse(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rst_pre got=%0d exp=2", state); end
        #3 reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", state); end
        checks++; if ({start, pause, game_over} !== 3'b000) begin errors++; $display("FAIL arst_ctl got=%b exp=000", {start, pause, game_over}); end
        checks++; if (score_rst_n !== 1'b1) begin errors++; $display("FAIL arst_clr got=%b exp=1", score_rst_n); end
        checks++; if (high_score !== '0) begin errors++; $display("FAIL arst_hs got=%0d exp=0", high_score); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", level); end
        @(negedge clk3);
        reset = 1'b1;
        @(negedge clk3);
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_high_score();
        test_hold();
        test_level();
        test_collide_pause();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
